// File: rtl/ifetcher_pkg.sv
// Shared definitions for the ifetcher fetch sequencer: state encoding and defaults.
package ifetcher_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ILEN_DEF = 32;
    localparam int PC_STEP  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DROP  = 3'd3,
        ST_FATAL = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/ifetcher_seq_timer.sv
// Request-age counter: cleared while idle, counts each cycle a request is alive,
// and saturates at TIMEOUT-1 so it can never wrap.
module ifetcher_seq_timer #(
    parameter int TIMEOUT = 64,
    localparam int CW = $clog2(TIMEOUT)
) (
    input  logic iClk,
    input  logic iResetn,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/ifetcher_fetch_seq.sv
// Fetch sequencer: owns the fetch PC, issues one cache request at a time, writes
// {pc,instr} into the receive FIFO and flushes it on redirects.
module ifetcher_fetch_seq
    import ifetcher_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ILEN     = ILEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 64
) (
    input  logic                 iClk,
    input  logic                 iResetn,
    input  logic                 iJumpVld,
    input  logic [XLEN-1:0]      iJumpPC,
    input  logic                 fromCache_resp,
    input  logic [ILEN-1:0]      fromCache_instr,
    output logic                 toCache_req,
    output logic [XLEN-1:0]      toCache_pc,
    input  logic                 iRcvFifoFull,
    output logic                 oRcvFifoWE,
    output logic [XLEN+ILEN-1:0] oRcvFifoWD,
    output logic                 oClear,
    output logic                 oTimeoutFatal,
    output logic [2:0]           oState
);

    fetch_state_e          state_q, state_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic                  we_q, we_d;
    logic [XLEN+ILEN-1:0]  wd_q, wd_d;
    logic                  clr_q, clr_d;
    logic                  tmr_clr, tmr_en, tmr_tc;

    // The timer starts counting in the request cycle, so TIMEOUT is measured from req.
    ifetcher_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .iClk    (iClk),
        .iResetn (iResetn),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .tc_o    (tmr_tc)
    );

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            we_q    <= 1'b0;
            wd_q    <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        we_d    = 1'b0;
        wd_d    = wd_q;
        clr_d   = 1'b0;
        tmr_clr = (state_q == ST_IDLE);
        tmr_en  = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_DROP);
        case (state_q)
            ST_IDLE: begin
                if (iJumpVld) begin
                    pc_d  = iJumpPC;
                    clr_d = 1'b1;
                end else if (!iRcvFifoFull) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (iJumpVld) begin
                    pc_d    = iJumpPC;
                    clr_d   = 1'b1;
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tmr_tc && !fromCache_resp) begin
                    state_d = ST_FATAL;
                end else if (iJumpVld) begin
                    // A redirect always beats a same-cycle response: the instruction is dropped.
                    pc_d    = iJumpPC;
                    clr_d   = 1'b1;
                    state_d = fromCache_resp ? ST_IDLE : ST_DROP;
                end else if (fromCache_resp) begin
                    we_d    = 1'b1;
                    wd_d    = {pc_q, fromCache_instr};
                    pc_d    = pc_q + XLEN'(PC_STEP);
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (tmr_tc && !fromCache_resp) begin
                    state_d = ST_FATAL;
                end else begin
                    if (iJumpVld) begin
                        pc_d  = iJumpPC;
                        clr_d = 1'b1;
                    end
                    if (fromCache_resp) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FATAL: begin
                state_d = ST_FATAL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign toCache_req   = (state_q == ST_ISSUE);
    assign toCache_pc    = pc_q;
    assign oRcvFifoWE    = we_q;
    assign oRcvFifoWD    = wd_q;
    assign oClear        = clr_q;
    assign oTimeoutFatal = (state_q == ST_FATAL);
    assign oState        = state_q;

endmodule

// File: tb/tb_ifetcher_fetch_seq.sv
// Bench for ifetcher_fetch_seq: directed table, hand-written corner sequences and a
// randomized run checked against a transaction-level model of the fetch rules.
module tb_ifetcher_fetch_seq;

    localparam int          XLEN     = 32;
    localparam int          ILEN     = 32;
    localparam int          TIMEOUT  = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        iClk;
    logic        iResetn;
    logic        iJumpVld;
    logic [31:0] iJumpPC;
    logic        fromCache_resp;
    logic [31:0] fromCache_instr;
    logic        toCache_req;
    logic [31:0] toCache_pc;
    logic        iRcvFifoFull;
    logic        oRcvFifoWE;
    logic [63:0] oRcvFifoWD;
    logic        oClear;
    logic        oTimeoutFatal;
    logic [2:0]  oState;

    ifetcher_fetch_seq #(
        .XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)
    ) dut (
        .iClk            (iClk),
        .iResetn         (iResetn),
        .iJumpVld        (iJumpVld),
        .iJumpPC         (iJumpPC),
        .fromCache_resp  (fromCache_resp),
        .fromCache_instr (fromCache_instr),
        .toCache_req     (toCache_req),
        .toCache_pc      (toCache_pc),
        .iRcvFifoFull    (iRcvFifoFull),
        .oRcvFifoWE      (oRcvFifoWE),
        .oRcvFifoWD      (oRcvFifoWD),
        .oClear          (oClear),
        .oTimeoutFatal   (oTimeoutFatal),
        .oState          (oState)
    );

    // ---------------- clock / reset ----------------
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // transaction-level model of the fetch stream
    logic        m_busy;
    logic        m_stale;
    int          m_pend;
    logic [31:0] m_fpc;
    logic [31:0] m_req_pc;
    logic [31:0] req_log[$];
    logic [63:0] wr_log[$];
    int          wr_cyc[$];

    typedef struct {
        logic        jump;
        logic [31:0] jpc;
        logic        resp;
        logic [31:0] instr;
        logic        full;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_we;
        logic [63:0] e_wd;
        logic        e_clr;
        logic [2:0]  e_st;
    } vec_t;

    vec_t tbl[28];

    localparam logic [31:0] IA = 32'hA0A0_0001;
    localparam logic [31:0] IB = 32'hB0B0_0002;
    localparam logic [31:0] IC = 32'hC0C0_0003;
    localparam logic [31:0] ID = 32'hD0D0_0004;
    localparam logic [31:0] IE = 32'hE0E0_0005;
    localparam logic [31:0] IF = 32'hF0F0_0006;
    localparam logic [31:0] IG = 32'h1234_5678;
    localparam logic [31:0] IH = 32'h8765_4321;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        iJumpVld        = 1'b0;
        iJumpPC         = 32'h0;
        fromCache_resp  = 1'b0;
        fromCache_instr = 32'h0;
        iRcvFifoFull    = 1'b0;
    endtask

    task automatic do_reset();
        iResetn = 1'b0;
        drive_idle();
        tick();
        tick();
        chk("rst_state", oState, 3'd0);
        chk("rst_pc", toCache_pc, RESET_PC);
        chk("rst_req", toCache_req, 1'b0);
        chk("rst_we", oRcvFifoWE, 1'b0);
        chk("rst_wd", oRcvFifoWD, 64'h0);
        chk("rst_clear", oClear, 1'b0);
        chk("rst_fatal", oTimeoutFatal, 1'b0);
        iResetn  = 1'b1;
        m_busy   = 1'b0;
        m_stale  = 1'b0;
        m_pend   = 0;
        m_fpc    = RESET_PC;
        m_req_pc = RESET_PC;
        req_log.delete();
        wr_log.delete();
        wr_cyc.delete();
    endtask

    // Cache + FIFO environment with a scoreboard driven by the fetch rules:
    // a request follows any cycle that is idle, not full and jump-free; a fresh
    // response is written one cycle later; every jump clears one cycle later.
    task automatic run_random(input int n, input int lmin, input int lmax,
                              input int jpct, input int fpct);
        logic        j, r, f, e_req, e_clr, e_we;
        logic [31:0] jpc, ins;
        logic [63:0] e_wd;
        for (int i = 0; i < n; i++) begin
            r   = m_busy && (m_pend == 0);
            j   = (int'($urandom_range(99)) < jpct);
            f   = (int'($urandom_range(99)) < fpct);
            jpc = $urandom() & 32'hFFFF_FFFC;
            ins = $urandom();
            iJumpVld        = j;
            iJumpPC         = jpc;
            fromCache_resp  = r;
            fromCache_instr = r ? ins : 32'h0;
            iRcvFifoFull    = f;
            e_req = !m_busy && !f && !j;
            e_clr = j;
            e_we  = r && !m_stale && !j;
            e_wd  = {m_req_pc, ins};
            if (j) begin
                m_fpc = jpc;
                if (m_busy) m_stale = 1'b1;
            end
            if (e_we) m_fpc = m_req_pc + 32'd4;
            if (r) m_busy = 1'b0;
            else if (m_busy) m_pend--;
            tick();
            chk("rnd_req", toCache_req, e_req);
            chk("rnd_clear", oClear, e_clr);
            chk("rnd_we", oRcvFifoWE, e_we);
            chk("rnd_fatal", oTimeoutFatal, 1'b0);
            if (e_we) chk("rnd_wd", oRcvFifoWD, e_wd);
            if (toCache_req) req_log.push_back(toCache_pc);
            if (oRcvFifoWE) begin
                wr_log.push_back(oRcvFifoWD);
                wr_cyc.push_back(cyc);
            end
            if (e_req) begin
                chk("rnd_req_pc", toCache_pc, m_fpc);
                m_busy   = 1'b1;
                m_stale  = 1'b0;
                m_req_pc = m_fpc;
                m_pend   = int'($urandom_range(lmax, lmin));
            end
        end
        drive_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic got;

        //                jump  jpc           resp  instr full  req   pc            we    wd                  clr   st
        tbl[0]  = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 64'h0,              1'b0, 3'd0};
        tbl[1]  = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 64'h0,              1'b0, 3'd0};
        tbl[2]  = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 32'h0,        1'b0, 64'h0,              1'b0, 3'd1};
        tbl[3]  = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 64'h0,              1'b0, 3'd2};
        tbl[4]  = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 64'h0,              1'b0, 3'd2};
        tbl[5]  = '{1'b0, 32'h0,        1'b1, IA,    1'b0, 1'b0, 32'h4,        1'b1, {32'h0, IA},        1'b0, 3'd0};
        tbl[6]  = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 32'h4,        1'b0, 64'h0,              1'b0, 3'd1};
        tbl[7]  = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 32'h4,        1'b0, 64'h0,              1'b0, 3'd2};
        tbl[8]  = '{1'b1, 32'h100,      1'b0, 32'h0, 1'b0, 1'b0, 32'h100,      1'b0, 64'h0,              1'b1, 3'd3};
        tbl[9]  = '{1'b0, 32'h0,        1'b1, IB,    1'b0, 1'b0, 32'h100,      1'b0, 64'h0,              1'b0, 3'd0};
        tbl[10] = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 32'h100,      1'b0, 64'h0,              1'b0, 3'd1};
        tbl[11] = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 32'h100,      1'b0, 64'h0,              1'b0, 3'd2};
        tbl[12] = '{1'b1, 32'h200,      1'b1, IC,    1'b0, 1'b0, 32'h200,      1'b0, 64'h0,              1'b1, 3'd0};
        tbl[13] = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 32'h200,      1'b0, 64'h0,              1'b0, 3'd1};
        tbl[14] = '{1'b1, 32'h300,      1'b0, 32'h0, 1'b0, 1'b0, 32'h300,      1'b0, 64'h0,              1'b1, 3'd3};
        tbl[15] = '{1'b1, 32'h400,      1'b0, 32'h0, 1'b0, 1'b0, 32'h400,      1'b0, 64'h0,              1'b1, 3'd3};
        tbl[16] = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 32'h400,      1'b0, 64'h0,              1'b0, 3'd3};
        tbl[17] = '{1'b0, 32'h0,        1'b1, ID,    1'b0, 1'b0, 32'h400,      1'b0, 64'h0,              1'b0, 3'd0};
        tbl[18] = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 32'h400,      1'b0, 64'h0,              1'b0, 3'd1};
        tbl[19] = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 32'h400,      1'b0, 64'h0,              1'b0, 3'd2};
        tbl[20] = '{1'b0, 32'h0,        1'b1, IE,    1'b0, 1'b0, 32'h404,      1'b1, {32'h400, IE},      1'b0, 3'd0};
        tbl[21] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 64'h0,            1'b1, 3'd0};
        tbl[22] = '{1'b0, 32'h0,        1'b1, IF,    1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 64'h0,             1'b0, 3'd1};
        tbl[23] = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 64'h0,             1'b0, 3'd2};
        tbl[24] = '{1'b0, 32'h0,        1'b1, IG,    1'b0, 1'b0, 32'h0,        1'b1, {32'hFFFF_FFFC, IG}, 1'b0, 3'd0};
        tbl[25] = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 32'h0,        1'b0, 64'h0,              1'b0, 3'd1};
        tbl[26] = '{1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 64'h0,              1'b0, 3'd2};
        tbl[27] = '{1'b0, 32'h0,        1'b1, IH,    1'b0, 1'b0, 32'h4,        1'b1, {32'h0, IH},        1'b0, 3'd0};

        iResetn = 1'b0;
        drive_idle();

        // Steady fetch: response in the fourth cycle after each request.
        do_reset();
        run_random(14, 4, 4, 0, 0);
        chk("t1_req_count", 64'(req_log.size()), 64'd3);
        chk("t1_wr_count", 64'(wr_log.size()), 64'd2);
        if (req_log.size() >= 3) begin
            chk("t1_req_pc0", req_log[0], 32'h0);
            chk("t1_req_pc1", req_log[1], 32'h4);
            chk("t1_req_pc2", req_log[2], 32'h8);
        end
        if (wr_log.size() >= 2) begin
            chk("t1_wr_pc0", wr_log[0][63:32], 32'h0);
            chk("t1_wr_pc1", wr_log[1][63:32], 32'h4);
            chk("t1_wr_gap", 64'(wr_cyc[1] - wr_cyc[0]), 64'd6);
        end

        // Directed table: full gating, stale drop, jump+resp, double jump, wrap.
        do_reset();
        for (int i = 0; i < 28; i++) begin
            iJumpVld        = tbl[i].jump;
            iJumpPC         = tbl[i].jpc;
            fromCache_resp  = tbl[i].resp;
            fromCache_instr = tbl[i].instr;
            iRcvFifoFull    = tbl[i].full;
            tick();
            chk($sformatf("tbl%0d_req", i), toCache_req, tbl[i].e_req);
            chk($sformatf("tbl%0d_pc", i), toCache_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_we", i), oRcvFifoWE, tbl[i].e_we);
            chk($sformatf("tbl%0d_clear", i), oClear, tbl[i].e_clr);
            chk($sformatf("tbl%0d_state", i), oState, tbl[i].e_st);
            chk($sformatf("tbl%0d_fatal", i), oTimeoutFatal, 1'b0);
            if (tbl[i].e_we) chk($sformatf("tbl%0d_wd", i), oRcvFifoWD, tbl[i].e_wd);
        end
        drive_idle();

        // Randomized traffic with jumps and FIFO back-pressure.
        do_reset();
        run_random(3000, 1, 6, 8, 25);

        // Timeout: no response ever comes.
        do_reset();
        got = 1'b0;
        for (int k = 0; k < 3 && !got; k++) begin
            tick();
            if (toCache_req) got = 1'b1;
        end
        chk("t5_req_seen", got, 1'b1);
        if (got) begin
            for (int k = 1; k <= 8; k++) begin
                tick();
                chk($sformatf("t5_fatal_at_%0d", k), oTimeoutFatal, (k == 8));
            end
            chk("t5_state_fatal", oState, 3'd4);
            iJumpVld        = 1'b1;
            iJumpPC         = 32'h500;
            fromCache_resp  = 1'b1;
            fromCache_instr = 32'hDEAD_BEEF;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("t5_fatal_sticky", oTimeoutFatal, 1'b1);
                chk("t5_no_req", toCache_req, 1'b0);
                chk("t5_no_clear", oClear, 1'b0);
                chk("t5_no_we", oRcvFifoWE, 1'b0);
                chk("t5_pc_hold", toCache_pc, RESET_PC);
            end
            drive_idle();
        end
        iResetn = 1'b0;
        #1;
        chk("t5_fatal_reset", oTimeoutFatal, 1'b0);
        chk("t5_state_reset", oState, 3'd0);
        tick();
        iResetn = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 2 && !got; k++) begin
            tick();
            if (toCache_req) begin
                got = 1'b1;
                chk("t5_resume_pc", toCache_pc, RESET_PC);
            end
        end
        chk("t5_resume_req", got, 1'b1);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
